// File: rtl/des_sbox_if.sv
// Handshake bundle between the E-box, the S-box substitution stage and the P-box side.
// The upstream and downstream producer/consumer uses master; the stage uses slave.
interface des_sbox_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] expanded;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sbox_out;

  modport master (
    output in_valid, expanded, subkey, out_ready,
    input  in_ready, out_valid, sbox_out
  );

  modport slave (
    input  in_valid, expanded, subkey, out_ready,
    output in_ready, out_valid, sbox_out
  );
endinterface

// File: rtl/des_sbox_stage.sv
// DES round substitution: XORs the expanded half with the subkey, then evaluates S1..S8,
// one S-box per clock, into a 32-bit pre-permutation word.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// BUSY  | evaluating S-box cnt+1 (8 cycles)
// DONE  | result held with out_valid high until out_ready
module des_sbox_stage (
  input  logic       clk,
  input  logic       rst,
  des_sbox_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Each S-box is 64 nibbles, row-major, entry (row*16 + col) at the top-most end first.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  state_t      state;
  logic [47:0] x;
  logic [2:0]  cnt;
  logic [31:0] result;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [5:0]  chunk_lsb;
  logic [5:0]  chunk;
  logic [5:0]  addr;
  logic [3:0]  nib;

  // Chunk i lives at x[47-6i -: 6]; its table entry sits at nibble offset 63-addr.
  always_comb begin
    chunk_lsb = {3'b000, ~cnt} * 6'd6;
    chunk     = x[chunk_lsb +: 6];
    addr      = {chunk[5], chunk[0], chunk[4:1]};
    nib       = SBOX[cnt][{~addr, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      cnt         <= '0;
      result      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x          <= bus.expanded ^ bus.subkey;
            cnt        <= '0;
            state      <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          result[{~cnt, 2'b00} +: 4] <= nib;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE never doubles as an accept; the next input waits a cycle.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sbox_out  = result;

endmodule

// File: doc/des_sbox_stage.md
# des_sbox_stage

Round-function substitution stage for the DES datapath. It sits directly downstream of the 48-bit expansion (E-box) output. It XORs the expanded right half with the 48-bit round subkey, then runs the result through the eight standard DES S-boxes, one S-box per clock, to produce the 32-bit pre-permutation (pre-P) value. A valid/ready handshake on both sides lets the round controller stall it.

## Interface
Parameters:
- none. S-box contents are fixed FIPS 46-3 tables held as internal constants.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents `expanded` and `subkey`.
- in_ready  output  1  stage can accept; high only in IDLE.
- expanded  input  48  E-box output; bit 47 = DES bit 1.
- subkey  input  48  round key K(n); bit 47 = DES bit 1.
- out_valid  output  1  `sbox_out` holds a finished result.
- out_ready  input  1  downstream accepts the result.
- sbox_out  output  32  concatenated S1..S8 outputs; S1 is in bits [31:28] and S8 in [3:0].

## Operation
- States:
  - IDLE: in_ready = 1.
  - BUSY: 8 cycles, one per S-box.
  - DONE: out_valid = 1.
- IDLE -> BUSY when in_valid && in_ready at a rising edge.
  - The stage registers x = expanded ^ subkey.
  - It clears the 3-bit index counter to 0.
- BUSY, index i (0..7):
  - Chunk c = x[47-6i -: 6], which is S-box S(i+1).
  - Row = {c[5], c[0]}; column = c[4:1].
  - The 4-bit table value is written to result[31-4i -: 4].
  - The counter increments by 1.
  - The transition to DONE happens on the edge that completes i = 7.
- DONE -> IDLE when out_ready is high at a rising edge.
  - out_valid stays high and sbox_out stays stable until then.
- in_ready is low in BUSY and DONE. Inputs presented then are ignored; upstream must hold them.
- No overlap: a new input is accepted only in IDLE. The DONE->IDLE edge does not also accept an input.
- sbox_out is driven from the result register in all states. Only DONE contents are meaningful.
- Inputs are captured once; changes to `expanded` or `subkey` after acceptance have no effect on the current operation.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - sbox_out = 32'h0.
  - x, counter = 0.
- Reset mid-operation (BUSY or DONE): the stage returns to IDLE immediately and asynchronously. The partial result is discarded and sbox_out reads 0.
- Latency: input accepted at edge N -> out_valid high after edge N+8.
- Throughput: at best one result per 10 cycles (1 accept cycle, 8 BUSY, at least 1 DONE).
- Back-pressure: with out_ready low, DONE holds indefinitely with no change to any output.
- in_ready falls after the accepting edge. It rises after the edge at which out_ready was sampled high in DONE.
- No combinational path exists from any input to any output. All outputs are registered or decoded from the state register.

## Test plan
- Reset then zero data: assert rst, check in_ready=1, out_valid=0, sbox_out=0. Release rst, apply expanded=0, subkey=0 -> out_valid after exactly 8 cycles with sbox_out=32'hEFA72C4D (row 0, col 0 of S1..S8).
- All-ones chunks: expanded=48'hFFFF_FFFF_FFFF, subkey=0 -> sbox_out=32'hD9CE3DCB (row 3, col 15 of each S-box).
- Key XOR: expanded=48'hFFFF_FFFF_FFFF, subkey=48'hFFFF_FFFF_FFFF -> sbox_out=32'hEFA72C4D. Also check in_ready=0 throughout BUSY/DONE.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid. sbox_out and out_valid must stay stable and in_ready must stay 0. A new in_valid pulse during that time must be ignored. Then raise out_ready for 1 cycle -> IDLE next cycle.
- Reset mid-BUSY: accept 48'hFFFF_FFFF_FFFF, assert rst at BUSY cycle 4 -> immediate IDLE, out_valid=0, sbox_out=0. The next transaction (zero inputs) must yield 32'hEFA72C4D after 8 cycles.
- Back-to-back: keep in_valid high with the two vectors queued and out_ready tied high. Results must appear in order, 32'hEFA72C4D then 32'hD9CE3DCB, 10 cycles apart.
